reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 15 +
 rtl/reg_bank_scrub.sv | 69 ++++++
 rtl/reg_bank.sv | 105 ++++++++++
 tb/tb_reg_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared defaults and state encoding for the register bank.
//   DATA_W_DEF : default entry width in bits
//   ADDR_W_DEF : default address width (DEPTH = 2**ADDR_W)
//   state_e    : scrub FSM states (IDLE, CLEAR)
package reg_bank_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/reg_bank_scrub.sv
// reg_bank_scrub: clear sequencer for the register bank. Walks every entry
// once, writing zero, after reset release or on a clear request.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr_req    : request a full clear (sampled in IDLE only)
//   clr_we     : zero-write strobe for the current counter address
//   clr_addr   : address being cleared this cycle
//   busy       : high while the clear sequence is running
module reg_bank_scrub
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Reset lands in CLEAR so the array is scrubbed before first use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        // Terminal count is detected explicitly rather than by wrap-around.
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr_addr = cnt_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: rtl/reg_bank.sv
// reg_bank: 1-write / 2-read register bank with registered read data,
// write-first bypass, optional hardwired-zero entry 0 and a clear sequencer.
//   clk, rst_n            : clock and asynchronous active-low reset
//   chip_enable           : gates all read and write requests
//   wr_en/wr_addr/wr_data : write port
//   rd_en                 : read request for both read ports
//   rd_addr1/rd_addr2     : read addresses
//   rd_data1/rd_data2     : registered read data (held when idle)
//   rd_valid              : one-cycle pulse marking new read data
//   clr_req               : request to zero all entries
//   busy                  : high while a clear is in progress
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chip_enable,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_acc, rd_acc;
  logic              zero1, zero2;
  logic [DATA_W-1:0] rd_data1_d, rd_data2_d;
  logic [DATA_W-1:0] rd_data1_q, rd_data2_q;
  logic              rd_valid_q;

  reg_bank_scrub #(.ADDR_W(ADDR_W)) u_scrub (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  // Writes to a hardwired-zero entry 0 are dropped here, so the bypass
  // path below never forwards them either.
  assign wr_acc = chip_enable && wr_en && !busy &&
                  !((ZERO_REG != 0) && (wr_addr == '0));
  assign rd_acc = chip_enable && rd_en && !busy;

  // Array has no reset; it is initialised only by the clear sequence.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign zero1 = (ZERO_REG != 0) && (rd_addr1 == '0);
  assign zero2 = (ZERO_REG != 0) && (rd_addr2 == '0);

  // Write-first: a same-cycle write to the read address is forwarded.
  always_comb begin
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    if (rd_acc) begin
      if (zero1)                            rd_data1_d = '0;
      else if (wr_acc && wr_addr == rd_addr1) rd_data1_d = wr_data;
      else                                  rd_data1_d = mem[rd_addr1];
      if (zero2)                            rd_data2_d = '0;
      else if (wr_acc && wr_addr == rd_addr2) rd_data2_d = wr_data;
      else                                  rd_data2_d = mem[rd_addr2];
    end
  end

  // Read output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      rd_valid_q <= rd_acc;
    end
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed self-checking bench for reg_bank. Two instances share
// stimulus: u_dut0 (ZERO_REG = 0) and u_dut1 (ZERO_REG = 1).
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chip_enable, wr_en, rd_en, clr_req;
  logic [2:0]  wr_addr, rd_addr1, rd_addr2;
  logic [15:0] wr_data;

  logic [15:0] d0_rd1, d0_rd2, d1_rd1, d1_rd2;
  logic        d0_vld, d0_busy, d1_vld, d1_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_bank #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .chip_enable(chip_enable),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d0_rd1), .rd_data2(d0_rd2), .rd_valid(d0_vld),
    .clr_req(clr_req), .busy(d0_busy)
  );

  reg_bank #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .chip_enable(chip_enable),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_rd1), .rd_data2(d1_rd2), .rd_valid(d1_vld),
    .clr_req(clr_req), .busy(d1_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    chip_enable = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
  endtask

  // Counts cycles with busy high, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (d0_busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; rd_addr1 = 3'(a); rd_addr2 = 3'(7 - a);
      tick();
      check_eq({tag, "_vld"}, {31'd0, d0_vld}, 32'd1);
      check_eq({tag, "_p1"}, {16'd0, d0_rd1}, 32'h0000);
      check_eq({tag, "_p2"}, {16'd0, d0_rd2}, 32'h0000);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", {31'd0, d0_busy}, 32'd1);
    check_eq("rst_vld", {31'd0, d0_vld}, 32'd0);
    check_eq("rst_rd1", {16'd0, d0_rd1}, 32'h0000);
    check_eq("rst_rd2", {16'd0, d0_rd2}, 32'h0000);

    // Reset release: exactly 8 busy cycles, then all zero.
    rst_n = 1'b1;
    count_busy(n);
    check_eq("init_busy_len", n, 32'd8);
    read_all_zero("init_zero");

    // Write then dual-port read of the same entry.
    write(3'd3, 16'hA5A5);
    rd_en = 1'b1; rd_addr1 = 3'd3; rd_addr2 = 3'd3;
    tick();
    rd_en = 1'b0;
    check_eq("rd3_vld", {31'd0, d0_vld}, 32'd1);
    check_eq("rd3_p1", {16'd0, d0_rd1}, 32'hA5A5);
    check_eq("rd3_p2", {16'd0, d0_rd2}, 32'hA5A5);
    tick();
    check_eq("rd3_vld_pulse", {31'd0, d0_vld}, 32'd0);
    check_eq("rd3_hold", {16'd0, d0_rd1}, 32'hA5A5);

    // Bypass on port 1, then on port 2.
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    rd_en = 1'b1; rd_addr1 = 3'd5; rd_addr2 = 3'd3;
    tick();
    check_eq("byp1_p1", {16'd0, d0_rd1}, 32'h1234);
    check_eq("byp1_p2", {16'd0, d0_rd2}, 32'hA5A5);
    wr_addr = 3'd6; wr_data = 16'h4321; rd_addr1 = 3'd3; rd_addr2 = 3'd6;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("byp2_p1", {16'd0, d0_rd1}, 32'hA5A5);
    check_eq("byp2_p2", {16'd0, d0_rd2}, 32'h4321);

    // chip_enable low gates both requests.
    chip_enable = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hDEAD;
    rd_en = 1'b1; rd_addr1 = 3'd5; rd_addr2 = 3'd5;
    tick();
    check_eq("ce_vld", {31'd0, d0_vld}, 32'd0);
    check_eq("ce_hold1", {16'd0, d0_rd1}, 32'hA5A5);
    check_eq("ce_hold2", {16'd0, d0_rd2}, 32'h4321);
    chip_enable = 1'b1; wr_en = 1'b0;
    rd_addr1 = 3'd3; rd_addr2 = 3'd5;
    tick();
    rd_en = 1'b0;
    check_eq("ce_mem3", {16'd0, d0_rd1}, 32'hA5A5);
    check_eq("ce_mem5", {16'd0, d0_rd2}, 32'h1234);

    // Entry 0: normal in dut0, hardwired zero in dut1.
    write(3'd0, 16'hBEEF);
    rd_en = 1'b1; rd_addr1 = 3'd0; rd_addr2 = 3'd0;
    tick();
    check_eq("z0_dut0", {16'd0, d0_rd1}, 32'hBEEF);
    check_eq("z0_dut1", {16'd0, d1_rd1}, 32'h0000);
    check_eq("z0_dut1_vld", {31'd0, d1_vld}, 32'd1);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h7777;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("z0_byp_dut0", {16'd0, d0_rd2}, 32'h7777);
    check_eq("z0_byp_dut1", {16'd0, d1_rd2}, 32'h0000);

    // Fill, then clear with a same-cycle write and read.
    for (int a = 0; a < 8; a++) write(3'(a), 16'hFFFF);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0F0F; clr_req = 1'b1;
    rd_en = 1'b1; rd_addr1 = 3'd2; rd_addr2 = 3'd7;
    tick();
    check_eq("clr_rd_vld", {31'd0, d0_vld}, 32'd1);
    check_eq("clr_rd_p1", {16'd0, d0_rd1}, 32'h0F0F);
    check_eq("clr_rd_p2", {16'd0, d0_rd2}, 32'hFFFF);
    // Requests held during the clear must be ignored.
    wr_addr = 3'd4; wr_data = 16'h1111; rd_addr1 = 3'd4;
    n = 0;
    while (d0_busy && n < 40) begin
      if (n > 0) check_eq("clr_busy_vld", {31'd0, d0_vld}, 32'd0);
      n++;
      tick();
    end
    idle_inputs();
    check_eq("clr_busy_len", n, 32'd8);
    check_eq("clr_hold_p1", {16'd0, d0_rd1}, 32'h0F0F);
    read_all_zero("clr_zero");

    // Reset in the middle of a clear restarts it from address 0.
    for (int a = 0; a < 8; a++) write(3'(a), 16'h5A00 + 16'(a));
    rd_en = 1'b1; rd_addr1 = 3'd6; rd_addr2 = 3'd1;
    tick();
    rd_en = 1'b0;
    check_eq("pre_rst_p1", {16'd0, d0_rd1}, 32'h5A06);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rd1", {16'd0, d0_rd1}, 32'h0000);
    check_eq("mid_rst_busy", {31'd0, d0_busy}, 32'd1);
    tick();
    rst_n = 1'b1;
    count_busy(n);
    check_eq("mid_rst_busy_len", n, 32'd8);
    read_all_zero("mid_rst_zero");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
